// File: rtl/alu_cmd_driver_if.sv
// alu_cmd_driver_if: command, alu-facing and response signals of alu_cmd_driver.
interface alu_cmd_driver_if #(
  parameter int N = 4
);
  logic         cmd_valid;
  logic         cmd_ready;
  logic [3:0]   cmd_opcode;
  logic [N-1:0] cmd_a;
  logic [N-1:0] cmd_b;
  logic         cmd_cin;
  logic [3:0]   alu_opcode;
  logic [N-1:0] alu_a;
  logic [N-1:0] alu_b;
  logic         alu_cin;
  logic [N-1:0] alu_y;
  logic         alu_cout;
  logic         alu_overflow;
  logic         alu_negative;
  logic         alu_zero;
  logic         rsp_valid;
  logic         rsp_ready;
  logic [N-1:0] rsp_y;
  logic [3:0]   rsp_flags;
  modport master (
    input  cmd_valid, cmd_opcode, cmd_a, cmd_b, cmd_cin,
    input  alu_y, alu_cout, alu_overflow, alu_negative, alu_zero,
    input  rsp_ready,
    output cmd_ready, alu_opcode, alu_a, alu_b, alu_cin,
    output rsp_valid, rsp_y, rsp_flags
  );
  modport slave (
    output cmd_valid, cmd_opcode, cmd_a, cmd_b, cmd_cin,
    output alu_y, alu_cout, alu_overflow, alu_negative, alu_zero,
    output rsp_ready,
    input  cmd_ready, alu_opcode, alu_a, alu_b, alu_cin,
    input  rsp_valid, rsp_y, rsp_flags
  );
endinterface

// File: rtl/alu_cmd_driver.sv
// alu_cmd_driver: issues one command to a combinational alu, waits SETTLE_CYCLES, returns result; ALU_DRV_STICKY_EN adds sticky flags.
module alu_cmd_driver #(
  parameter int N             = 4,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  alu_cmd_driver_if.master bus,
  output logic             busy
`ifdef ALU_DRV_STICKY_EN
  ,
  input  logic             sticky_clr,
  output logic [3:0]       sticky_flags
`endif
);
  localparam logic [1:0] IDLE = 2'd0, WAIT = 2'd1, RESP = 2'd2;
  localparam logic [3:0] CNT_LOAD = 4'(SETTLE_CYCLES - 1);
  logic [1:0] state;
  logic [3:0] cnt;
  logic       accept;
  logic       capture;
  logic [3:0] flags;
  always_comb begin
    accept        = bus.cmd_valid && state == IDLE;
    capture       = state == WAIT && cnt == 4'd0;
    flags         = {bus.alu_cout, bus.alu_overflow, bus.alu_negative, bus.alu_zero};
    bus.cmd_ready = state == IDLE && rst_n;
    bus.rsp_valid = state == RESP;
    busy          = state != IDLE;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      cnt            <= 4'd0;
      bus.alu_opcode <= 4'd0;
      bus.alu_a      <= {N{1'b0}};
      bus.alu_b      <= {N{1'b0}};
      bus.alu_cin    <= 1'b0;
      bus.rsp_y      <= {N{1'b0}};
      bus.rsp_flags  <= 4'd0;
    end else begin
      state <= accept ? WAIT : capture ? RESP : (state == RESP && bus.rsp_ready) ? IDLE : state;
      cnt   <= accept ? CNT_LOAD : (state == WAIT && cnt != 4'd0) ? cnt - 4'd1 : cnt;
      if (accept) begin
        bus.alu_opcode <= bus.cmd_opcode;
        bus.alu_a      <= bus.cmd_a;
        bus.alu_b      <= bus.cmd_b;
        bus.alu_cin    <= bus.cmd_cin;
      end
      if (capture) begin
        bus.rsp_y     <= bus.alu_y;
        bus.rsp_flags <= flags;
      end
    end
  end
`ifdef ALU_DRV_STICKY_EN
  // a clear coinciding with a capture drops only the history, never the new flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sticky_flags <= 4'd0;
    else if (capture) sticky_flags <= sticky_clr ? flags : sticky_flags | flags;
    else if (sticky_clr) sticky_flags <= 4'd0;
  end
`endif
endmodule

// File: tb/tb_alu_cmd_driver.sv
// tb_alu_cmd_driver: randomized self-checking bench with a delayed behavioural alu and reference model.
module tb_alu_cmd_driver;
  localparam int N = 4;
  localparam int S = 2;
  localparam int W = N + 1;
  logic clk = 1'b0;
  logic rst_n;
  logic busy;
  logic sticky_clr;
`ifdef ALU_DRV_STICKY_EN
  logic [3:0] sticky_flags;
  logic [3:0] sticky_exp;
`endif
  int checks = 0;
  int errors = 0;
  alu_cmd_driver_if #(.N(N)) bus ();
  alu_cmd_driver #(.N(N), .SETTLE_CYCLES(S)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus),
    .busy(busy)
`ifdef ALU_DRV_STICKY_EN
    ,
    .sticky_clr(sticky_clr),
    .sticky_flags(sticky_flags)
`endif
  );
  always #5 clk = ~clk;
  // returns {y, cout, overflow, negative, zero}
  function automatic logic [N+3:0] alu_ref(input logic [3:0] op, input logic [N-1:0] a, input logic [N-1:0] b, input logic cin);
    logic [N:0] s;
    logic v;
    v = 1'b0;
    case (op)
      4'd0: begin
        s = {1'b0, a} + {1'b0, b} + W'(cin);
        v = (a[N-1] == b[N-1]) && (s[N-1] != a[N-1]);
      end
      4'd1: begin
        s = {1'b0, a} + {1'b0, ~b} + W'(1);
        v = (a[N-1] != b[N-1]) && (s[N-1] != a[N-1]);
      end
      4'd2: s = {1'b0, a & b};
      4'd3: s = {1'b0, a | b};
      4'd4: s = {1'b0, a ^ b};
      default: s = '0;
    endcase
    return {s[N-1:0], s[N], v, s[N-1], s[N-1:0] == '0};
  endfunction
  // alu stand-in that only reflects its inputs one cycle late, so an early capture sees stale data
  logic [3:0] d_op;
  logic [N-1:0] d_a, d_b;
  logic d_cin;
  always @(posedge clk) {d_op, d_a, d_b, d_cin} <= {bus.alu_opcode, bus.alu_a, bus.alu_b, bus.alu_cin};
  assign {bus.alu_y, bus.alu_cout, bus.alu_overflow, bus.alu_negative, bus.alu_zero} = alu_ref(d_op, d_a, d_b, d_cin);
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic chk_reset_outputs();
    chk("rst_alu", {bus.alu_opcode, bus.alu_a, bus.alu_b, bus.alu_cin}, 0);
    chk("rst_rsp", {bus.rsp_valid, bus.rsp_y, bus.rsp_flags}, 0);
    chk("rst_ready", bus.cmd_ready, 0);
    chk("rst_busy", busy, 0);
`ifdef ALU_DRV_STICKY_EN
    chk("rst_sticky", sticky_flags, 0);
    sticky_exp = 4'd0;
`endif
  endtask
  task automatic run(input logic [3:0] op, input logic [N-1:0] a, input logic [N-1:0] b, input logic cin, input int hold, input logic clr);
    logic [N+3:0] e;
    logic [12:0] issued;
    int k;
    e = alu_ref(op, a, b, cin);
    issued = {op, a, b, cin};
    bus.cmd_opcode = op;
    bus.cmd_a = a;
    bus.cmd_b = b;
    bus.cmd_cin = cin;
    bus.cmd_valid = 1'b1;
    bus.rsp_ready = 1'b0;
    k = 0;
    while (!bus.cmd_ready && k < 50) begin
      @(posedge clk); #1;
      k++;
    end
    chk("accept_wait", k, 0);
    @(posedge clk); #1;
    chk("alu_issue", {bus.alu_opcode, bus.alu_a, bus.alu_b, bus.alu_cin}, issued);
    chk("busy_wait", busy, 1);
    bus.cmd_opcode = 4'($urandom);
    bus.cmd_a = N'($urandom);
    bus.cmd_b = N'($urandom);
    bus.cmd_cin = 1'($urandom);
    for (int i = 1; i < S; i++) begin
      @(posedge clk); #1;
      chk("early_rsp", bus.rsp_valid, 0);
      chk("wait_ready", bus.cmd_ready, 0);
    end
    sticky_clr = clr;
    @(posedge clk); #1;
    sticky_clr = 1'b0;
    chk("rsp_valid", bus.rsp_valid, 1);
    chk("rsp_data", {bus.rsp_y, bus.rsp_flags}, e);
`ifdef ALU_DRV_STICKY_EN
    sticky_exp = clr ? e[3:0] : sticky_exp | e[3:0];
    chk("sticky", sticky_flags, sticky_exp);
`endif
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      chk("hold_rsp", {bus.rsp_valid, bus.rsp_y, bus.rsp_flags}, {1'b1, e});
      chk("hold_ready", bus.cmd_ready, 0);
      chk("hold_alu", {bus.alu_opcode, bus.alu_a, bus.alu_b, bus.alu_cin}, issued);
    end
    bus.rsp_ready = 1'b1;
    @(posedge clk); #1;
    bus.rsp_ready = 1'b0;
    bus.cmd_valid = 1'b0;
    chk("post_hs", {bus.rsp_valid, busy, bus.cmd_ready}, 3'b001);
    chk("post_hs_data", {bus.rsp_y, bus.rsp_flags, bus.alu_a}, {e, a});
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1);
  end
  initial begin
    int seen;
    rst_n = 1'b0;
    sticky_clr = 1'b0;
    bus.cmd_valid = 1'b0;
    bus.rsp_ready = 1'b0;
    bus.cmd_opcode = 4'd0;
    bus.cmd_a = '0;
    bus.cmd_b = '0;
    bus.cmd_cin = 1'b0;
    #12;
    chk_reset_outputs();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rel_ready", {bus.cmd_ready, busy}, 2'b10);
    run(4'd0, 4'b0001, 4'b0001, 1'b0, 0, 1'b0);
    chk("add_const", {bus.rsp_y, bus.rsp_flags}, 8'b0010_0000);
    run(4'd0, 4'b0111, 4'b0001, 1'b0, 5, 1'b0);
    chk("ovf_const", {bus.rsp_y, bus.rsp_flags}, 8'b1000_0110);
    run(4'd1, 4'b0011, 4'b0101, 1'b0, 0, 1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk_reset_outputs();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rel2_ready", {bus.cmd_ready, busy}, 2'b10);
    bus.cmd_opcode = 4'd0;
    bus.cmd_a = 4'b0101;
    bus.cmd_b = 4'b0010;
    bus.cmd_valid = 1'b1;
    bus.rsp_ready = 1'b1;
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
    seen = int'(bus.rsp_valid);
    chk("midwait_issue", bus.alu_a, 4'b0101);
    @(posedge clk); #1;
    seen += int'(bus.rsp_valid);
    rst_n = 1'b0;
    #1;
    chk_reset_outputs();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 2 * S + 4; i++) begin
      @(posedge clk); #1;
      seen += int'(bus.rsp_valid) + int'(busy) + int'(!bus.cmd_ready);
    end
    chk("midwait_no_rsp", seen, 0);
    chk("midwait_alu", bus.alu_a, 0);
    bus.rsp_ready = 1'b0;
    run(4'd0, 4'b0111, 4'b0001, 1'b0, 0, 1'b0);
    run(4'd0, 4'b1111, 4'b0001, 1'b0, 0, 1'b0);
`ifdef ALU_DRV_STICKY_EN
    chk("sticky_all", sticky_flags, 4'b1111);
`endif
    run(4'd0, 4'b0001, 4'b0001, 1'b0, 0, 1'b1);
`ifdef ALU_DRV_STICKY_EN
    chk("sticky_clr_cap", sticky_flags, 4'b0000);
`endif
    for (int i = 0; i < 24; i++)
      run(4'($urandom_range(0, 7)), N'($urandom), N'($urandom), 1'($urandom), int'($urandom_range(0, 3)), 1'($urandom_range(0, 3) == 0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
